super_pixel_readout_arbiter: RTL and testbench

Parametrised readout arbiter for one super pixel, successor to the fixed 8-pixel, single-word super-pixel readout. It collects finished hit words (TOA gray code, FTOA LFSR, ToT LFSR) from N_PIX pixels with round-robin arbitration and buffers them in a local FIFO. It merges the local words with the column daisy chain coming from upstream, using a selectable priority mode. It sits between the pixel front-ends and the column bus and runs entirely in the 40 MHz domain.

---
 rtl/super_pixel_pkg.sv | 37 +++
 rtl/super_pixel_readout_arbiter_if.sv | 24 ++
 rtl/hypix_sync_fifo.sv | 53 +++++
 rtl/super_pixel_readout_arbiter.sv | 130 +++++++++++++
 tb/tb_super_pixel_readout_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/super_pixel_pkg.sv
// Shared widths and column-word layout for the super pixel readout.
// Defaults describe the standard 8-pixel super pixel.
package super_pixel_pkg;

   localparam int TOA_W      = 9;
   localparam int FTOA_W     = 5;
   localparam int TOT_W      = 8;
   localparam int N_PIX_DEF  = 8;
   localparam int PIX_ADDR_W = $clog2(N_PIX_DEF);

   typedef struct packed {
      logic [TOA_W-1:0]      toa;
      logic [FTOA_W-1:0]     ftoa;
      logic [TOT_W-1:0]      tot;
      logic [PIX_ADDR_W-1:0] pix_addr;
      logic                  col;
   } col_word_t;

   localparam int COL_DATA_W = $bits(col_word_t);

   function automatic col_word_t pack_word(
      input logic [TOA_W-1:0]      toa,
      input logic [FTOA_W-1:0]     ftoa,
      input logic [TOT_W-1:0]      tot,
      input logic [PIX_ADDR_W-1:0] pix_addr,
      input logic                  col
   );
      col_word_t w;
      w.toa      = toa;
      w.ftoa     = ftoa;
      w.tot      = tot;
      w.pix_addr = pix_addr;
      w.col      = col;
      return w;
   endfunction

endpackage

// File: rtl/super_pixel_readout_arbiter_if.sv
// Column daisy-chain bus: upstream word in, merged word out, ready both ways.
// The master modport is the arbiter side.
interface super_pixel_readout_arbiter_if
   import super_pixel_pkg::*;
#(
   parameter int DATA_W = COL_DATA_W
);
   logic [DATA_W-1:0] last_data;
   logic              last_valid;
   logic              shake_hands_last;
   logic              shake_hands_next;
   logic [DATA_W-1:0] arbiter_data;
   logic              arbiter_valid;

   modport master (
      input  last_data, last_valid, shake_hands_next,
      output shake_hands_last, arbiter_data, arbiter_valid
   );

   modport slave (
      output last_data, last_valid, shake_hands_next,
      input  shake_hands_last, arbiter_data, arbiter_valid
   );
endinterface

// File: rtl/hypix_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head word is visible on rdata.
// Push while full is accepted only when a pop frees a slot on the same edge.
module hypix_sync_fifo #(
   parameter int  DATA_W = 26,
   parameter int  DEPTH  = 4,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int LVL_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              full,
   output logic              empty,
   output logic [LVL_W-1:0]  level
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/super_pixel_readout_arbiter.sv
// Super pixel readout: round-robin capture of pixel hits into a local FIFO,
// merged with the upstream column chain into one registered output word.
module super_pixel_readout_arbiter #(
   parameter int  N_PIX      = super_pixel_pkg::N_PIX_DEF,
   parameter int  TOA_W      = super_pixel_pkg::TOA_W,
   parameter int  FTOA_W     = super_pixel_pkg::FTOA_W,
   parameter int  TOT_W      = super_pixel_pkg::TOT_W,
   parameter int  FIFO_DEPTH = 4,
   localparam int ADDR_W     = $clog2(N_PIX),
   localparam int DATA_W     = TOA_W + FTOA_W + TOT_W + ADDR_W + 1,
   localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                    clk_40MHz,
   input  logic                    rst_n,
   input  logic                    addr_col,
   input  logic                    arb_mode,
   input  logic [N_PIX-1:0]        pix_mask,
   input  logic [N_PIX-1:0]        pix_valid,
   input  logic [N_PIX*TOA_W-1:0]  pix_toa,
   input  logic [N_PIX*FTOA_W-1:0] pix_ftoa,
   input  logic [N_PIX*TOT_W-1:0]  pix_tot,
   output logic [N_PIX-1:0]        pix_ack,
   super_pixel_readout_arbiter_if.master bus,
   output logic [LVL_W-1:0]        fifo_level,
   output logic [15:0]             hit_cnt
);

   logic [N_PIX-1:0]  cand;
   logic [N_PIX-1:0]  discard;
   logic [ADDR_W-1:0] rr_ptr;
   logic [ADDR_W-1:0] grant_idx;
   logic [ADDR_W-1:0] scan_idx;
   logic              grant_any;
   logic [DATA_W-1:0] push_word;
   logic [DATA_W-1:0] fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic              load;
   logic              local_avail;
   logic              contended;
   logic              sel_up;
   logic              take_up;
   logic              alt_flag;
   logic [DATA_W-1:0] out_data_p1;
   logic              out_vld_p1;

   assign cand    = pix_valid & ~pix_mask;
   assign discard = pix_valid & pix_mask;

   // Descending scan so the candidate closest to rr_ptr is the last one written
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      scan_idx  = '0;
      for (int k = N_PIX - 1; k >= 0; k--) begin
         scan_idx = rr_ptr + ADDR_W'(k);
         if (cand[scan_idx]) begin
            grant_any = 1'b1;
            grant_idx = scan_idx;
         end
      end
   end

   assign push_word = {pix_toa[int'(grant_idx)*TOA_W +: TOA_W],
                       pix_ftoa[int'(grant_idx)*FTOA_W +: FTOA_W],
                       pix_tot[int'(grant_idx)*TOT_W +: TOT_W],
                       grant_idx, addr_col};

   assign load        = ~out_vld_p1 | bus.shake_hands_next;
   assign local_avail = ~fifo_empty;
   assign contended   = local_avail & bus.last_valid;
   // alt_flag low favours the local FIFO on a contended alternate-mode load
   assign sel_up      = bus.last_valid & (~local_avail | ~arb_mode | alt_flag);
   assign take_up     = load & sel_up;
   assign pop         = load & local_avail & ~sel_up;
   assign push        = grant_any & (~fifo_full | pop);

   assign pix_ack              = rst_n ? (discard | ({N_PIX{push}} & (N_PIX'(1) << grant_idx))) : '0;
   assign bus.shake_hands_last = rst_n & take_up;
   assign bus.arbiter_data     = out_data_p1;
   assign bus.arbiter_valid    = out_vld_p1;

   hypix_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk_40MHz),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata (push_word),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // Output register stage
   always_ff @(posedge clk_40MHz or negedge rst_n) begin
      if (!rst_n) begin
         out_data_p1 <= '0;
         out_vld_p1  <= 1'b0;
         alt_flag    <= 1'b0;
      end else if (load) begin
         if (take_up) begin
            out_data_p1 <= bus.last_data;
            out_vld_p1  <= 1'b1;
         end else if (pop) begin
            out_data_p1 <= fifo_head;
            out_vld_p1  <= 1'b1;
         end else begin
            out_vld_p1  <= 1'b0;
         end
         if (arb_mode && contended) alt_flag <= ~alt_flag;
      end
   end

   always_ff @(posedge clk_40MHz or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr  <= '0;
         hit_cnt <= '0;
      end else if (push) begin
         rr_ptr <= grant_idx + ADDR_W'(1);
         if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_super_pixel_readout_arbiter.sv
// Directed bench with a queue-based reference model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_super_pixel_readout_arbiter;
   import super_pixel_pkg::*;

   localparam int NP    = 8;
   localparam int DEPTH = 4;
   localparam int DW    = COL_DATA_W;

   logic              clk_40MHz = 1'b0;
   logic              rst_n;
   logic              addr_col;
   logic              arb_mode;
   logic [NP-1:0]     pix_mask;
   logic [NP-1:0]     pix_valid;
   logic [NP*TOA_W-1:0]  pix_toa;
   logic [NP*FTOA_W-1:0] pix_ftoa;
   logic [NP*TOT_W-1:0]  pix_tot;
   logic [NP-1:0]     pix_ack;
   logic [2:0]        fifo_level;
   logic [15:0]       hit_cnt;

   super_pixel_readout_arbiter_if bus ();

   super_pixel_readout_arbiter dut (
      .clk_40MHz (clk_40MHz),
      .rst_n     (rst_n),
      .addr_col  (addr_col),
      .arb_mode  (arb_mode),
      .pix_mask  (pix_mask),
      .pix_valid (pix_valid),
      .pix_toa   (pix_toa),
      .pix_ftoa  (pix_ftoa),
      .pix_tot   (pix_tot),
      .pix_ack   (pix_ack),
      .bus       (bus.master),
      .fifo_level(fifo_level),
      .hit_cnt   (hit_cnt)
   );

   always #5 clk_40MHz = ~clk_40MHz;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [DW-1:0] mq[$];
   logic          mv;
   logic [DW-1:0] md;
   int            mrr;
   logic          malt;
   int            mhit;

   // Observation logs filled from the DUT by the compare process
   logic [NP-1:0] ack_log[$];
   logic [DW-1:0] xfer_log[$];
   int            shl_cnt;
   logic [DW-1:0] up_q[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] pw(input int i, input logic col);
      return pack_word(pix_toa[i*TOA_W +: TOA_W], pix_ftoa[i*FTOA_W +: FTOA_W],
                       pix_tot[i*TOT_W +: TOT_W], PIX_ADDR_W'(i), col);
   endfunction

   task automatic model_reset();
      mq.delete();
      mv = 1'b0; md = '0; mrr = 0; malt = 1'b0; mhit = 0;
   endtask

   task automatic model_comb(output logic [NP-1:0] ack, output logic shl,
                             output logic pop, output int gi);
      logic load, lav, uav, sel_up;
      logic [NP-1:0] cand;
      ack = '0; shl = 1'b0; pop = 1'b0; gi = -1;
      if (rst_n !== 1'b1) return;
      load = !mv || bus.shake_hands_next;
      lav  = mq.size() > 0;
      uav  = bus.last_valid;
      if (lav && uav) sel_up = !arb_mode || malt;
      else            sel_up = uav;
      shl  = load && sel_up;
      pop  = load && lav && !sel_up;
      cand = pix_valid & ~pix_mask;
      if (mq.size() < DEPTH || pop)
         for (int k = 0; k < NP; k++)
            if (gi < 0 && cand[(mrr + k) % NP]) gi = (mrr + k) % NP;
      ack = pix_valid & pix_mask;
      if (gi >= 0) ack[gi] = 1'b1;
   endtask

   task automatic model_step();
      logic [NP-1:0] ack;
      logic shl, pop, both;
      int gi;
      model_comb(ack, shl, pop, gi);
      both = (mq.size() > 0) && bus.last_valid;
      if (!mv || bus.shake_hands_next) begin
         if (shl)      begin md = bus.last_data;  mv = 1'b1; end
         else if (pop) begin md = mq.pop_front(); mv = 1'b1; end
         else          mv = 1'b0;
         if (arb_mode && both) malt = !malt;
      end
      if (gi >= 0) begin
         mq.push_back(pw(gi, addr_col));
         mrr = (gi + 1) % NP;
         if (mhit < 65535) mhit++;
      end
   endtask

   initial forever begin
      @(posedge clk_40MHz);
      if (rst_n === 1'b1) model_step();
   end

   // Compare process: DUT outputs against the model every cycle
   initial forever begin
      logic [NP-1:0] eack;
      logic eshl, epop;
      int egi;
      @(negedge clk_40MHz);
      model_comb(eack, eshl, epop, egi);
      chk("arbiter_valid", 64'(bus.arbiter_valid), 64'(mv));
      chk("arbiter_data", 64'(bus.arbiter_data), 64'(md));
      chk("fifo_level", 64'(fifo_level), 64'(mq.size()));
      chk("hit_cnt", 64'(hit_cnt), 64'(mhit));
      chk("pix_ack", 64'(pix_ack), 64'(eack));
      chk("shake_hands_last", 64'(bus.shake_hands_last), 64'(eshl));
      if (pix_ack != '0) ack_log.push_back(pix_ack);
      if (bus.shake_hands_last) shl_cnt++;
      if (bus.arbiter_valid && bus.shake_hands_next) xfer_log.push_back(bus.arbiter_data);
   end

   task automatic drive_up();
      bus.last_valid = up_q.size() > 0;
      bus.last_data  = (up_q.size() > 0) ? up_q[0] : '0;
   endtask

   // Pixels and upstream react to the handshakes seen before each edge
   task automatic tick();
      logic [NP-1:0] a;
      logic u;
      @(negedge clk_40MHz);
      a = pix_ack;
      u = bus.shake_hands_last;
      @(posedge clk_40MHz);
      #1;
      pix_valid = pix_valid & ~a;
      if (u && up_q.size() > 0) void'(up_q.pop_front());
      drive_up();
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      pix_valid = '0;
      pix_mask  = '0;
      up_q.delete();
      drive_up();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic setup_pixels();
      for (int i = 0; i < NP; i++) begin
         pix_toa[i*TOA_W +: TOA_W]    = TOA_W'(9'h040 + i * 37);
         pix_ftoa[i*FTOA_W +: FTOA_W] = FTOA_W'(3 + i * 5);
         pix_tot[i*TOT_W +: TOT_W]    = TOT_W'(8'h03 + i * 8'h11);
      end
   endtask

   task automatic contention(input logic mode, input logic [DW-1:0] seq [9]);
      do_reset();
      arb_mode = mode;
      bus.shake_hands_next = 1'b0;
      addr_col = 1'b1;
      pix_valid = 8'h0F;
      run(6);
      chk("fill_level", 64'(fifo_level), 64'd3);
      chk("fill_valid", 64'(bus.arbiter_valid), 64'd1);
      xfer_log.delete();
      shl_cnt = 0;
      for (int k = 0; k < 5; k++) up_q.push_back(DW'(26'h2ABCD00 + k));
      drive_up();
      bus.shake_hands_next = 1'b1;
      run(12);
      chk("order_len", 64'(xfer_log.size()), 64'd9);
      for (int k = 0; k < 9 && k < xfer_log.size(); k++)
         chk("order_word", 64'(xfer_log[k]), 64'(seq[k]));
      chk("shl_cycles", 64'(shl_cnt), 64'd5);
   endtask

   initial begin
      logic [DW-1:0] seq [9];
      logic [DW-1:0] u [5];
      rst_n = 1'b1;
      addr_col = 1'b0;
      arb_mode = 1'b0;
      pix_mask = '0;
      pix_valid = '0;
      bus.shake_hands_next = 1'b0;
      bus.last_valid = 1'b0;
      bus.last_data = '0;
      shl_cnt = 0;
      model_reset();
      setup_pixels();
      #2;
      do_reset();
      chk("rst_valid", 64'(bus.arbiter_valid), 64'd0);
      chk("rst_data", 64'(bus.arbiter_data), 64'd0);
      chk("rst_level", 64'(fifo_level), 64'd0);
      chk("rst_hits", 64'(hit_cnt), 64'd0);

      // Single hit, two-cycle latency
      bus.shake_hands_next = 1'b1;
      addr_col = 1'b1;
      pix_toa[0 +: TOA_W] = 9'h1A5;
      pix_ftoa[0 +: FTOA_W] = 5'h13;
      pix_tot[0 +: TOT_W] = 8'h7F;
      ack_log.delete();
      pix_valid = 8'h01;
      tick();
      chk("s1_valid_early", 64'(bus.arbiter_valid), 64'd0);
      chk("s1_level", 64'(fifo_level), 64'd1);
      tick();
      chk("s1_valid", 64'(bus.arbiter_valid), 64'd1);
      chk("s1_data", 64'(bus.arbiter_data), 64'({9'h1A5, 5'h13, 8'h7F, 3'd0, 1'b1}));
      chk("s1_hits", 64'(hit_cnt), 64'd1);
      run(3);
      chk("s1_acks", 64'(ack_log.size()), 64'd1);
      chk("s1_ack0", 64'(ack_log[0]), 64'h01);
      setup_pixels();

      // All pixels, stalled downstream fills the FIFO
      do_reset();
      bus.shake_hands_next = 1'b0;
      addr_col = 1'b0;
      ack_log.delete();
      xfer_log.delete();
      pix_valid = 8'hFF;
      run(10);
      chk("s2_level", 64'(fifo_level), 64'd4);
      chk("s2_acks", 64'(ack_log.size()), 64'd5);
      chk("s2_waiting", 64'(pix_valid), 64'hE0);
      bus.shake_hands_next = 1'b1;
      run(14);
      chk("s2_acks_all", 64'(ack_log.size()), 64'd8);
      for (int i = 0; i < 8 && i < ack_log.size(); i++)
         chk("s2_ack_order", 64'(ack_log[i]), 64'(8'h01 << i));
      chk("s2_xfers", 64'(xfer_log.size()), 64'd8);
      for (int i = 0; i < 8 && i < xfer_log.size(); i++)
         chk("s2_xfer_order", 64'(xfer_log[i]), 64'(pw(i, 1'b0)));

      // Masked channels acknowledged and dropped
      do_reset();
      bus.shake_hands_next = 1'b1;
      pix_mask = 8'h0F;
      ack_log.delete();
      xfer_log.delete();
      pix_valid = 8'hFF;
      run(12);
      chk("s3_first_ack", 64'(ack_log[0]), 64'h1F);
      chk("s3_xfers", 64'(xfer_log.size()), 64'd4);
      for (int i = 0; i < 4 && i < xfer_log.size(); i++)
         chk("s3_xfer", 64'(xfer_log[i]), 64'(pw(i + 4, 1'b0)));
      chk("s3_hits", 64'(hit_cnt), 64'd4);
      pix_mask = '0;

      // Upstream-first and alternate merging
      for (int k = 0; k < 5; k++) u[k] = DW'(26'h2ABCD00 + k);
      seq = '{pw(0, 1'b1), u[0], u[1], u[2], u[3], u[4], pw(1, 1'b1), pw(2, 1'b1), pw(3, 1'b1)};
      contention(1'b0, seq);
      seq = '{pw(0, 1'b1), pw(1, 1'b1), u[0], pw(2, 1'b1), u[1], pw(3, 1'b1), u[2], u[3], u[4]};
      contention(1'b1, seq);

      // Asynchronous reset with words held
      do_reset();
      arb_mode = 1'b0;
      bus.shake_hands_next = 1'b0;
      pix_valid = 8'h0F;
      run(6);
      chk("s6_level", 64'(fifo_level), 64'd3);
      chk("s6_valid", 64'(bus.arbiter_valid), 64'd1);
      rst_n = 1'b0;
      model_reset();
      pix_valid = 8'h42;
      #1;
      chk("s6_async_valid", 64'(bus.arbiter_valid), 64'd0);
      chk("s6_async_data", 64'(bus.arbiter_data), 64'd0);
      chk("s6_async_level", 64'(fifo_level), 64'd0);
      chk("s6_async_hits", 64'(hit_cnt), 64'd0);
      chk("s6_async_ack", 64'(pix_ack), 64'd0);
      tick();
      rst_n = 1'b1;
      bus.shake_hands_next = 1'b1;
      ack_log.delete();
      xfer_log.delete();
      tick();
      chk("s6_hits", 64'(hit_cnt), 64'd1);
      chk("s6_first_ack", 64'(ack_log[0]), 64'h02);
      run(4);
      chk("s6_first_word", 64'(xfer_log[0]), 64'(pw(1, 1'b1)));
      chk("s6_hits_end", 64'(hit_cnt), 64'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
